// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Brief    : PS/2 keyboard receiver. Synchronizes and de-glitches the raw
//             ps2_clk/ps2_data pins, deframes 11-bit device-to-host frames,
//             folds E0/F0 prefixes into the following scan byte and emits one
//             key_valid strobe per make or break code.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMER_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [8:0] key_code,
    output logic       key_break,
    output logic       frame_err
);

    localparam int                   c_fcnt_w    = $clog2(FILTER_LEN + 1);
    localparam logic [c_fcnt_w-1:0]  c_filt_last = c_fcnt_w'(FILTER_LEN - 1);
    localparam logic [TIMER_W-1:0]   c_timeout   = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]           c_pfx_ext   = 8'hE0;
    localparam logic [7:0]           c_pfx_brk   = 8'hF0;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    logic                r_clk_meta;
    logic                r_clk_sync;
    logic                r_dat_meta;
    logic                r_dat_sync;
    logic                r_clk_filt;
    logic [c_fcnt_w-1:0] r_filt_cnt;
    logic                r_fall;
    logic [1:0]          r_state;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic                r_ext;
    logic                r_brk;
    logic [TIMER_W-1:0]  r_timer;
    logic                w_frame_ok;

    // Two-flop synchronizers; idle-high reset value avoids a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Clock de-glitch: flip only after FILTER_LEN disagreeing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync != r_clk_filt) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_clk_filt <= r_clk_sync;
                    r_filt_cnt <= '0;
                    r_fall     <= r_clk_filt;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Odd parity over data+parity, and stop bit (sampled now) must be high.
    assign w_frame_ok = r_dat_sync & (^{r_shift, r_parity});

    // Frame deserializer, timeout watchdog and prefix/byte layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_timer   <= '0;
            key_valid <= 1'b0;
            key_code  <= 9'h000;
            key_break <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (r_state == c_st_idle) begin
                r_timer <= '0;
                if (r_fall && !r_dat_sync) begin
                    r_state   <= c_st_data;
                    r_bit_cnt <= 3'd0;
                end
            end else if (r_fall) begin
                r_timer <= '0;
                case (r_state)
                    c_st_data: begin
                        r_shift   <= {r_dat_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_st_parity;
                        end
                    end
                    c_st_parity: begin
                        r_parity <= r_dat_sync;
                        r_state  <= c_st_stop;
                    end
                    default: begin
                        r_state <= c_st_idle;
                        if (!w_frame_ok) begin
                            frame_err <= 1'b1;
                            r_ext     <= 1'b0;
                            r_brk     <= 1'b0;
                        end else if (r_shift == c_pfx_ext) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == c_pfx_brk) begin
                            r_brk <= 1'b1;
                        end else begin
                            key_valid <= 1'b1;
                            key_code  <= {r_ext, r_shift};
                            key_break <= r_brk;
                            r_ext     <= 1'b0;
                            r_brk     <= 1'b0;
                        end
                    end
                endcase
            end else if (r_timer == c_timeout) begin
                // Keyboard stopped clocking mid-frame: drop it and any prefixes.
                r_state   <= c_st_idle;
                r_timer   <= '0;
                frame_err <= 1'b1;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Brief    : Self-checking bench for ps2_key_decoder. Directed scenarios plus
//             a random byte stream, checked against an event-queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int TIMER_W        = 10;
    localparam int CLK_NS         = 10;
    localparam int HALF_NS        = 24 * CLK_NS;

    typedef struct packed {
        logic       err;
        logic [8:0] code;
        logic       brk;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic [8:0] key_code;
    logic       key_break;
    logic       frame_err;

    int   total = 0;
    int   bad   = 0;
    evt_t exp_q[$];
    evt_t m_evt;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    logic [8:0] m_last_code = 9'h000;
    logic       m_last_brk  = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_W       (TIMER_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_break(key_break),
        .frame_err(frame_err)
    );

    always #(CLK_NS / 2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: what one received frame means at the key-event level.
    task automatic model_frame(input logic [7:0] b, input logic good);
        evt_t e;
        if (!good) begin
            e = '{err: 1'b1, code: 9'h000, brk: 1'b0};
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e = '{err: 1'b0, code: {m_ext, b}, brk: m_brk};
            exp_q.push_back(e);
            m_last_code = {m_ext, b};
            m_last_brk  = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        #(HALF_NS);
        ps2_clk = 1'b0;
        #(HALF_NS);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        model_frame(b, !(bad_par || bad_stop));
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        #(HALF_NS);
        check_eq("pending_events", 16'(exp_q.size()), 16'd0);
        check_eq("code_hold", 16'(key_code), 16'(m_last_code));
        check_eq("break_hold", 16'(key_break), 16'(m_last_brk));
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    // Scoreboard: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (key_valid || frame_err)) begin
            check_eq("both_strobes", 16'(key_valid & frame_err), 16'd0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_event", {14'd0, key_valid, frame_err}, 16'd0);
            end else begin
                m_evt = exp_q.pop_front();
                check_eq("event_kind", 16'(frame_err), 16'(m_evt.err));
                if (!m_evt.err) begin
                    check_eq("key_code", 16'(key_code), 16'(m_evt.code));
                    check_eq("key_break", 16'(key_break), 16'(m_evt.brk));
                end
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_key_valid", 16'(key_valid), 16'd0);
        check_eq("rst_key_code", 16'(key_code), 16'h000);
        check_eq("rst_key_break", 16'(key_break), 16'd0);
        check_eq("rst_frame_err", 16'(frame_err), 16'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // Make, break, make
        send_good(8'h1C);
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'h1C);

        // Extended make and break
        send_good(8'hE0);
        send_good(8'h75);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'hF0);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h6B);

        // Parity error clears pending break; then stop-bit error
        send_good(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_good(8'h1C);
        send_good(8'hE0);
        send_frame(8'h33, 1'b0, 1'b1);
        send_good(8'h33);

        // Timeout after start + 4 data bits
        send_good(8'hF0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        model_frame(8'h00, 1'b0);
        repeat (TIMEOUT_CYCLES + 40) @(posedge clk);
        check_eq("timeout_event", 16'(exp_q.size()), 16'd0);
        send_good(8'h1C);

        // Short low glitch on ps2_clk with data low must not start a frame
        ps2_data = 1'b0;
        @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
        ps2_data = 1'b1;
        repeat (50) @(posedge clk);
        send_good(8'h2A);

        // Reset mid-frame after an E0 prefix
        send_good(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #(HALF_NS / 2 + 3);
        rst = 1'b1;
        #1;
        check_eq("midrst_key_valid", 16'(key_valid), 16'd0);
        check_eq("midrst_key_code", 16'(key_code), 16'h000);
        check_eq("midrst_key_break", 16'(key_break), 16'd0);
        check_eq("midrst_frame_err", 16'(frame_err), 16'd0);
        ps2_data = 1'b1;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_last_code = 9'h000;
        m_last_brk  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        send_good(8'h1C);

        // Random byte stream with occasional corrupted frames
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int         sel;
            int         err_sel;
            sel     = $urandom_range(0, 3);
            err_sel = $urandom_range(0, 9);
            b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            send_frame(b, err_sel == 0, err_sel == 1);
        end

        repeat (20) @(posedge clk);
        check_eq("final_pending", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
